// File: rtl/disp_pkg.sv
// Shared display types and the leading-zero rule used by the scan controller
// and the decoder wrapper.
package disp_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DATA_W = 64;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    // True when digit idx (above digit 0) and every digit above it are zero.
    // The value is passed zero-extended, so bits above the real width read as 0.
    function automatic logic is_lead_zero(input logic [MAX_DATA_W-1:0] value,
                                          input logic [31:0]           idx);
        return (idx != 0) && ((value >> (NIBBLE_W * idx)) == '0);
    endfunction

endpackage

// File: rtl/hex_display_scan_if.sv
// Bundle between the CPU port / display driver and the hex scan controller.
interface hex_display_scan_if import disp_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned NUM_DIGITS = DATA_WIDTH / NIBBLE_W;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  disp_on;
    nibble_t               digit_val;
    logic                  digit_en;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic [DATA_WIDTH-1:0] shown_val;

    modport master (
        output wr_en, wr_data, disp_on,
        input  digit_val, digit_en, digit_sel, shown_val
    );

    modport slave (
        input  wr_en, wr_data, disp_on,
        output digit_val, digit_en, digit_sel, shown_val
    );

endinterface

// File: rtl/scan_tick.sv
// Free-running slot divider: counts 0..DIV-1 and flags the terminal count.
module scan_tick #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);
    localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    if (DIV == 0) begin : g_bad_div
        $error("scan_tick: DIV must be >= 1");
    end

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == TERM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_display_scan.sv
// Holds a CPU-written value and time-multiplexes its nibbles onto one 7-seg
// decoder, with one-hot digit select, leading-zero blanking and display enable.
module hex_display_scan import disp_pkg::*; #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic              clk,
    input  logic              reset,
    hex_display_scan_if.slave bus
);
    localparam int unsigned      NUM_DIGITS = DATA_WIDTH / NIBBLE_W;
    localparam int unsigned      IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    if (DATA_WIDTH < NIBBLE_W || (DATA_WIDTH % NIBBLE_W) != 0 || DATA_WIDTH > MAX_DATA_W)
    begin : g_bad_width
        $error("hex_display_scan: DATA_WIDTH must be a multiple of 4 in 4..64");
    end

    logic                  w_tick;
    logic [DATA_WIDTH-1:0] r_shown_val;
    logic                  r_loaded;
    logic [IDX_W-1:0]      r_digit_idx;
    logic [NUM_DIGITS-1:0] r_digit_sel;
    nibble_t               r_digit_val;
    logic                  r_digit_en;
    logic [NUM_DIGITS-1:0] w_sel;
    nibble_t               w_val;
    logic                  w_lz;

    scan_tick #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shown_val <= '0;
            r_loaded    <= 1'b0;
        end else if (bus.wr_en) begin
            r_shown_val <= bus.wr_data;
            r_loaded    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit_idx <= '0;
        end else if (w_tick) begin
            r_digit_idx <= (r_digit_idx == LAST_IDX) ? '0 : r_digit_idx + 1'b1;
        end
    end

    // Outputs derive from registered state only, so a write landing on a slot
    // wrap is already visible in the first cycle of the new slot.
    always_comb begin
        w_sel = NUM_DIGITS'(1) << r_digit_idx;
        w_val = r_shown_val[NIBBLE_W * r_digit_idx +: NIBBLE_W];
        w_lz  = (BLANK_LZ != 0) && is_lead_zero(MAX_DATA_W'(r_shown_val), 32'(r_digit_idx));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit_sel <= NUM_DIGITS'(1);
            r_digit_val <= '0;
            r_digit_en  <= 1'b0;
        end else begin
            r_digit_sel <= w_sel;
            r_digit_val <= w_val;
            r_digit_en  <= bus.disp_on & r_loaded & ~w_lz;
        end
    end

    assign bus.digit_sel = r_digit_sel;
    assign bus.digit_val = r_digit_val;
    assign bus.digit_en  = r_digit_en;
    assign bus.shown_val = r_shown_val;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: two instances (blanking on/off) against a
// cycle-level reference built from slot arithmetic.
module tb_hex_display_scan;

    localparam int unsigned DW  = 8;
    localparam int unsigned DIV = 4;
    localparam int unsigned ND  = DW / 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          disp_on = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: edges since reset, held value and loaded flag.
    int            m_t;
    logic [DW-1:0] m_val;
    logic          m_loaded;
    logic [ND-1:0] e_sel;
    logic [3:0]    e_val;
    logic          e_en_a;
    logic          e_en_b;
    logic [DW-1:0] e_shown;

    typedef struct {
        logic [DW-1:0] data;
        logic          disp;
        logic [3:0]    v0;
        logic          e0;
        logic [3:0]    v1;
        logic          e1;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    hex_display_scan_if #(.DATA_WIDTH(DW)) bus_a ();
    hex_display_scan_if #(.DATA_WIDTH(DW)) bus_b ();

    assign bus_a.wr_en   = wr_en;
    assign bus_a.wr_data = wr_data;
    assign bus_a.disp_on = disp_on;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_data = wr_data;
    assign bus_b.disp_on = disp_on;

    hex_display_scan #(.DATA_WIDTH(DW), .SCAN_DIV(DIV), .BLANK_LZ(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    hex_display_scan #(.DATA_WIDTH(DW), .SCAN_DIV(DIV), .BLANK_LZ(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs after an edge reflect the state before it; then the state moves.
    task automatic model_edge();
        int            idx;
        logic [DW-1:0] upper;
        logic          lz;
        if (reset) begin
            e_sel    = ND'(1);
            e_val    = '0;
            e_en_a   = 1'b0;
            e_en_b   = 1'b0;
            m_val    = '0;
            m_loaded = 1'b0;
            m_t      = 0;
        end else begin
            idx    = (m_t / DIV) % ND;
            e_sel  = ND'(1) << idx;
            upper  = m_val >> (4 * idx);
            e_val  = upper[3:0];
            lz     = (idx != 0) && (upper == 0);
            e_en_a = disp_on && m_loaded && !lz;
            e_en_b = disp_on && m_loaded;
            if (wr_en) begin
                m_val    = wr_data;
                m_loaded = 1'b1;
            end
            m_t++;
        end
        e_shown = m_val;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("sel_a", 32'(bus_a.digit_sel), 32'(e_sel));
        check("val_a", 32'(bus_a.digit_val), 32'(e_val));
        check("en_a", 32'(bus_a.digit_en), 32'(e_en_a));
        check("shown_a", 32'(bus_a.shown_val), 32'(e_shown));
        check("sel_b", 32'(bus_b.digit_sel), 32'(e_sel));
        check("val_b", 32'(bus_b.digit_val), 32'(e_val));
        check("en_b", 32'(bus_b.digit_en), 32'(e_en_b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'h3A, disp: 1'b1, v0: 4'hA, e0: 1'b1, v1: 4'h3, e1: 1'b1};
        vecs[1] = '{data: 8'h05, disp: 1'b1, v0: 4'h5, e0: 1'b1, v1: 4'h0, e1: 1'b0};
        vecs[2] = '{data: 8'h00, disp: 1'b1, v0: 4'h0, e0: 1'b1, v1: 4'h0, e1: 1'b0};
        vecs[3] = '{data: 8'hF0, disp: 1'b1, v0: 4'h0, e0: 1'b1, v1: 4'hF, e1: 1'b1};
        vecs[4] = '{data: 8'h3A, disp: 1'b0, v0: 4'hA, e0: 1'b0, v1: 4'h3, e1: 1'b0};
        vecs[5] = '{data: 8'h10, disp: 1'b1, v0: 4'h0, e0: 1'b1, v1: 4'h1, e1: 1'b1};

        // Reset with no writes: blank, scanning 4 cycles per digit.
        disp_on = 1'b1;
        do_reset();
        check("rst_sel", 32'(bus_a.digit_sel), 32'h1);
        check("rst_en", 32'(bus_a.digit_en), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("idle_en", 32'(bus_a.digit_en), 32'h0);
            check("idle_shown", 32'(bus_a.shown_val), 32'h0);
            check("idle_sel", 32'(bus_a.digit_sel), (((k - 1) / 4) % 2 == 0) ? 32'h1 : 32'h2);
        end

        // Write latency: two cycles from the strobe to the digit outputs.
        do_reset();
        do_write(8'h3A);
        check("lat1_en", 32'(bus_a.digit_en), 32'h0);
        cycle();
        check("lat2_en", 32'(bus_a.digit_en), 32'h1);
        check("lat2_val", 32'(bus_a.digit_val), 32'hA);

        // Display off for 10 cycles, then back on.
        for (int k = 0; k < 3; k++) cycle();
        disp_on = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("off_en", 32'(bus_a.digit_en), 32'h0);
        end
        disp_on = 1'b1;
        cycle();
        check("on_en", 32'(bus_a.digit_en), 32'h1);

        // Table of held values and the steady per-digit result.
        for (int v = 0; v < 6; v++) begin
            disp_on = vecs[v].disp;
            do_write(vecs[v].data);
            for (int k = 0; k < 3; k++) cycle();
            for (int k = 0; k < 8; k++) begin
                cycle();
                if (bus_a.digit_sel == 2'b01) begin
                    check("tbl_v0", 32'(bus_a.digit_val), 32'(vecs[v].v0));
                    check("tbl_e0", 32'(bus_a.digit_en), 32'(vecs[v].e0));
                end else begin
                    check("tbl_v1", 32'(bus_a.digit_val), 32'(vecs[v].v1));
                    check("tbl_e1", 32'(bus_a.digit_en), 32'(vecs[v].e1));
                end
                check("tbl_nb_en", 32'(bus_b.digit_en), 32'(vecs[v].disp));
            end
        end
        disp_on = 1'b1;

        // Write landing on the edge that moves the slot from digit 0 to 1.
        do_reset();
        do_write(8'h12);
        while (m_t % 8 != 3) cycle();
        do_write(8'h34);
        cycle();
        check("wrap_sel", 32'(bus_a.digit_sel), 32'h2);
        check("wrap_val", 32'(bus_a.digit_val), 32'h3);

        // Mid-slot reset restarts a full slot on digit 0.
        do_write(8'h3A);
        while (m_t % 4 != 1) cycle();
        do_reset();
        check("mrst_sel", 32'(bus_a.digit_sel), 32'h1);
        check("mrst_en", 32'(bus_a.digit_en), 32'h0);
        check("mrst_shown", 32'(bus_a.shown_val), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("mrst_slot0", 32'(bus_a.digit_sel), 32'h1);
        end
        cycle();
        check("mrst_slot1", 32'(bus_a.digit_sel), 32'h2);

        // Random traffic against the reference.
        for (int k = 0; k < 400; k++) begin
            wr_en   = ($urandom % 4) == 0;
            wr_data = DW'($urandom);
            if ($urandom % 2 == 0) wr_data = wr_data & 8'h0F;
            disp_on = ($urandom % 8) != 0;
            reset   = ($urandom % 64) == 0;
            cycle();
        end
        reset = 1'b0;
        wr_en = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
